sfx_sequencer: RTL and testbench

//  Upstream of the audio engine. Turns game-logic event levels (jump button, player death) into timed,

---
 rtl/sfx_sequencer.sv | 132 +++++++++++++
 tb/tb_sfx_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: turns jump/death event edges into timed, mutually exclusive hold levels,
// each preceded by a silent gap. Define SFX_RETRIGGER_EN to let a new jump edge restart a jump tone.
module sfx_sequencer #(
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned JUMP_TICKS  = 25_000_000,
  parameter int unsigned DEATH_TICKS = 100_000_000,
  parameter int unsigned GAP_TICKS   = 4
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       jump_in,
  input  logic       dead_in,
  output logic       jump,
  output logic       isdead,
  output logic       busy,
  output logic [1:0] sfx_state
);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StGap   = 2'b01,
    StJump  = 2'b10,
    StDeath = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    PendNone  = 2'b00,
    PendJump  = 2'b01,
    PendDeath = 2'b10
  } pend_e;

  localparam logic [CNT_W-1:0] GapLoad   = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] JumpLoad  = CNT_W'(JUMP_TICKS - 1);
  localparam logic [CNT_W-1:0] DeathLoad = CNT_W'(DEATH_TICKS - 1);

  state_e           state_q, state_d;
  pend_e            pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             jump_hist_q, dead_hist_q;
  logic             jump_ev, dead_ev;
  logic             jump_d, isdead_d, busy_d;
  logic [1:0]       sfx_state_d;

  assign jump_ev = jump_in & ~jump_hist_q;
  assign dead_ev = dead_in & ~dead_hist_q;

  // History flops reset high so a level held through reset is not an event.
  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      state_q     <= StIdle;
      pend_q      <= PendNone;
      cnt_q       <= '0;
      jump_hist_q <= 1'b1;
      dead_hist_q <= 1'b1;
      jump        <= 1'b0;
      isdead      <= 1'b0;
      busy        <= 1'b0;
      sfx_state   <= 2'b00;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      jump_hist_q <= jump_in;
      dead_hist_q <= dead_in;
      jump        <= jump_d;
      isdead      <= isdead_d;
      busy        <= busy_d;
      sfx_state   <= sfx_state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    unique case (state_q)
      StIdle: begin
        if (dead_ev || jump_ev) begin
          pend_d  = dead_ev ? PendDeath : PendJump;
          cnt_d   = GapLoad;
          state_d = StGap;
        end
      end
      StGap: begin
        if (dead_ev) begin
          pend_d = PendDeath;
        end else if (jump_ev && pend_q == PendNone) begin
          pend_d = PendJump;
        end
        // A death edge on the last gap cycle still takes priority via pend_d.
        if (cnt_q == '0) begin
          if (pend_d == PendDeath) begin
            state_d = StDeath;
            cnt_d   = DeathLoad;
          end else begin
            state_d = StJump;
            cnt_d   = JumpLoad;
          end
          pend_d = PendNone;
        end
      end
      StJump: begin
        if (dead_ev) begin
          pend_d  = PendDeath;
          cnt_d   = GapLoad;
          state_d = StGap;
`ifdef SFX_RETRIGGER_EN
        end else if (jump_ev) begin
          pend_d  = PendJump;
          cnt_d   = GapLoad;
          state_d = StGap;
`endif
        end else if (cnt_q == '0) begin
          state_d = StIdle;
        end
      end
      StDeath: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_comb begin
    jump_d      = (state_d == StJump);
    isdead_d    = (state_d == StDeath);
    busy_d      = (state_d != StIdle);
    sfx_state_d = state_d;
  end

endmodule

// File: tb/tb_sfx_sequencer.sv
// Scoreboard bench for sfx_sequencer: expected output runs are queued with stimulus and checked by a
// monitor on every change of the output vector. Honours SFX_RETRIGGER_EN.
module tb_sfx_sequencer;

  localparam logic [4:0] VIdle  = 5'b00_0_0_0;
  localparam logic [4:0] VGap   = 5'b01_0_0_1;
  localparam logic [4:0] VJump  = 5'b10_1_0_1;
  localparam logic [4:0] VDeath = 5'b11_0_1_1;

  logic       clk = 1'b0;
  logic       rstn;
  logic       jump_in, dead_in;
  logic       jump, isdead, busy;
  logic [1:0] sfx_state;

  typedef struct {
    logic [4:0] vec;
    int         len;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  sfx_sequencer #(
    .CNT_W      (8),
    .JUMP_TICKS (8),
    .DEATH_TICKS(16),
    .GAP_TICKS  (2)
  ) dut (
    .CLK100MHZ (clk),
    .CPU_RESETN(rstn),
    .jump_in   (jump_in),
    .dead_in   (dead_in),
    .jump      (jump),
    .isdead    (isdead),
    .busy      (busy),
    .sfx_state (sfx_state)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // len = length of the run that ends at this change; 0 means unchecked (idle runs).
  task automatic expect_run(logic [4:0] v, int l);
    exp_t e;
    e.vec = v;
    e.len = l;
    exp_q.push_back(e);
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) tick(1);
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: each change of {state, jump, isdead, busy} is one presented output.
  initial begin
    logic [4:0] prev_vec, vec;
    int         run_len;
    exp_t       e;
    prev_vec = VIdle;
    run_len  = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        vec = {sfx_state, jump, isdead, busy};
        if (vec !== prev_vec) begin
          if (exp_q.size() == 0) begin
            check("unexpected_change", {27'd0, vec}, {27'd0, prev_vec});
          end else begin
            e = exp_q.pop_front();
            check("out_vec", {27'd0, vec}, {27'd0, e.vec});
            if (e.len != 0) check("run_len", run_len, e.len);
          end
          prev_vec = vec;
          run_len  = 1;
        end else begin
          run_len++;
        end
      end
    end
  end

  initial begin
    rstn    = 1'b0;
    jump_in = 1'b1;
    dead_in = 1'b0;
    tick(3);
    rstn = 1'b1;
    tick(1);
    check("rst_state", sfx_state, 2'b00);
    check("rst_jump", jump, 1'b0);
    check("rst_isdead", isdead, 1'b0);
    check("rst_busy", busy, 1'b0);
    tick(2);
    check("held_no_event", {sfx_state, busy}, 3'b000);
    mon_en  = 1'b1;
    jump_in = 1'b0;
    tick(2);

    // Plain jump
    expect_run(VGap, 0);
    expect_run(VJump, 2);
    expect_run(VIdle, 8);
    jump_in = 1'b1;
    drain("drain_jump");
    jump_in = 1'b0;
    tick(3);

    // Simultaneous jump and death: death wins
    expect_run(VGap, 0);
    expect_run(VDeath, 2);
    expect_run(VIdle, 16);
    jump_in = 1'b1;
    dead_in = 1'b1;
    drain("drain_both");
    jump_in = 1'b0;
    dead_in = 1'b0;
    tick(3);

    // Death preempts jump at jump cycle 3
    expect_run(VGap, 0);
    expect_run(VJump, 2);
    expect_run(VGap, 3);
    expect_run(VDeath, 2);
    expect_run(VIdle, 16);
    jump_in = 1'b1;
    tick(5);
    dead_in = 1'b1;
    drain("drain_preempt");
    jump_in = 1'b0;
    dead_in = 1'b0;
    tick(3);

    // Second jump edge during JUMP
    expect_run(VGap, 0);
    expect_run(VJump, 2);
`ifdef SFX_RETRIGGER_EN
    expect_run(VGap, 2);
    expect_run(VJump, 2);
`endif
    expect_run(VIdle, 8);
    jump_in = 1'b1;
    tick(3);
    jump_in = 1'b0;
    tick(1);
    jump_in = 1'b1;
    drain("drain_retrig");
    jump_in = 1'b0;
    tick(3);

    // Reset during DEATH cycle 5, then a fresh death edge
    expect_run(VGap, 0);
    expect_run(VDeath, 2);
    expect_run(VIdle, 5);
    dead_in = 1'b1;
    tick(7);
    rstn = 1'b0;
    tick(1);
    check("abort_isdead", isdead, 1'b0);
    check("abort_state", sfx_state, 2'b00);
    rstn = 1'b1;
    drain("drain_abort");
    tick(2);
    dead_in = 1'b0;
    tick(1);
    expect_run(VGap, 0);
    expect_run(VDeath, 2);
    expect_run(VIdle, 16);
    dead_in = 1'b1;
    drain("drain_after_rst");
    dead_in = 1'b0;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
